// File: rtl/fp_exe_queue.sv
// Request FIFO and single-issue sequencer in front of fp_unit.
// Define FP_QUEUE_WDOG_EN to enable the WAIT-state watchdog.
package fp_wire;

  typedef struct packed {
    logic fmadd;
    logic fmsub;
    logic fnmsub;
    logic fnmadd;
    logic fadd;
    logic fsub;
    logic fmul;
    logic fdiv;
    logic fsqrt;
    logic fsgnj;
    logic fcmp;
    logic fmax;
    logic fclass;
    logic fmv_i2f;
    logic fmv_f2i;
    logic fcvt_i2f;
    logic fcvt_f2i;
    logic fcvt_f2f;
  } fp_operation_type;

  localparam fp_operation_type init_fp_operation = '0;

endpackage

module fp_exe_queue
  import fp_wire::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic             reset,
  input  logic             clock,
  input  logic [63:0]      req_data1,
  input  logic [63:0]      req_data2,
  input  logic [63:0]      req_data3,
  input  logic [1:0]       req_fmt,
  input  logic [2:0]       req_rm,
  input  fp_operation_type req_op,
  input  logic             req_enable,
  output logic             req_full,
  output logic [63:0]      exe_data1,
  output logic [63:0]      exe_data2,
  output logic [63:0]      exe_data3,
  output logic [1:0]       exe_fmt,
  output logic [2:0]       exe_rm,
  output fp_operation_type exe_op,
  output logic             exe_enable,
  input  logic [63:0]      exe_result,
  input  logic [4:0]       exe_flags,
  input  logic             exe_ready,
  output logic [63:0]      rsp_result,
  output logic [4:0]       rsp_flags,
  output logic [3:0]       rsp_tag,
  output logic             rsp_valid,
  output logic             wdog_err
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0
      || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_cfg
    $error("fp_exe_queue: DEPTH or TIMEOUT out of range");
  end

  typedef struct packed {
    logic [63:0]      d1;
    logic [63:0]      d2;
    logic [63:0]      d3;
    logic [1:0]       fmt;
    logic [2:0]       rm;
    fp_operation_type op;
    logic [3:0]       tag;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [3:0]    tag_cnt;
  logic [3:0]    held_tag;
  state_t        state;
  state_t        state_nxt;
  logic          push;
  logic          pop;
  logic          done;
  logic          tmo;

  // full is judged on the registered count, so a same-cycle pop
  // never makes room for a push
  assign req_full = count == (AW+1)'(DEPTH);
  assign push     = req_enable & ~req_full;
  assign pop      = state == ISSUE;
  assign done     = state == WAIT && exe_ready;
  assign head     = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      tag_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr + 1'b1;
        tag_cnt <= tag_cnt + 4'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= '{
        d1:  req_data1,
        d2:  req_data2,
        d3:  req_data3,
        fmt: req_fmt,
        rm:  req_rm,
        op:  req_op,
        tag: tag_cnt
      };
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      held_tag <= '0;
    end else begin
      state <= state_nxt;
      if (pop) held_tag <= head.tag;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      state == IDLE:  if (count != '0) state_nxt = ISSUE;
      state == ISSUE: state_nxt = WAIT;
      state == WAIT:  if (done || tmo) state_nxt = IDLE;
      default:        state_nxt = IDLE;
    endcase
  end

  assign exe_enable = pop;
  assign exe_data1  = head.d1;
  assign exe_data2  = head.d2;
  assign exe_data3  = head.d3;
  assign exe_fmt    = head.fmt;
  assign exe_rm     = head.rm;
  assign exe_op     = pop ? head.op : init_fp_operation;

  always_ff @(posedge clock) begin
    if (!reset) begin
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_tag    <= '0;
    end else begin
      rsp_valid <= done | tmo;
      if (done) begin
        rsp_result <= exe_result;
        rsp_flags  <= exe_flags;
        rsp_tag    <= held_tag;
      end else if (tmo) begin
        rsp_result <= '0;
        rsp_flags  <= '0;
        rsp_tag    <= held_tag;
      end
    end
  end

`ifdef FP_QUEUE_WDOG_EN
  logic [7:0] wd_cnt;
  logic       wd_err;

  // fires on the TIMEOUT-th WAIT cycle without exe_ready
  assign tmo = state == WAIT && !exe_ready
            && wd_cnt == 8'(TIMEOUT - 1);
  assign wdog_err = wd_err;

  always_ff @(posedge clock) begin
    if (!reset) begin
      wd_cnt <= '0;
      wd_err <= 1'b0;
    end else begin
      if (pop) wd_cnt <= '0;
      else if (state == WAIT) wd_cnt <= wd_cnt + 8'd1;
      if (tmo) wd_err <= 1'b1;
    end
  end
`else
  assign tmo      = 1'b0;
  assign wdog_err = 1'b0;
`endif

endmodule

// File: tb/tb_fp_exe_queue.sv
// Bench for fp_exe_queue: directed scenarios plus random traffic
// against a queue-based reference model of the request stream.
module tb_fp_exe_queue;
  import fp_wire::*;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 10;
  localparam int OPW     = $bits(fp_operation_type);

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic [63:0]      req_data1, req_data2, req_data3;
  logic [1:0]       req_fmt;
  logic [2:0]       req_rm;
  fp_operation_type req_op;
  logic             req_enable = 1'b0;
  logic             req_full;
  logic [63:0]      exe_data1, exe_data2, exe_data3;
  logic [1:0]       exe_fmt;
  logic [2:0]       exe_rm;
  fp_operation_type exe_op;
  logic             exe_enable;
  logic [63:0]      exe_result = '0;
  logic [4:0]       exe_flags = '0;
  logic             exe_ready = 1'b0;
  logic [63:0]      rsp_result;
  logic [4:0]       rsp_flags;
  logic [3:0]       rsp_tag;
  logic             rsp_valid;
  logic             wdog_err;

  always #5 clock = ~clock;

  fp_exe_queue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .reset(reset), .clock(clock),
    .req_data1(req_data1), .req_data2(req_data2),
    .req_data3(req_data3), .req_fmt(req_fmt),
    .req_rm(req_rm), .req_op(req_op),
    .req_enable(req_enable), .req_full(req_full),
    .exe_data1(exe_data1), .exe_data2(exe_data2),
    .exe_data3(exe_data3), .exe_fmt(exe_fmt),
    .exe_rm(exe_rm), .exe_op(exe_op),
    .exe_enable(exe_enable), .exe_result(exe_result),
    .exe_flags(exe_flags), .exe_ready(exe_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .rsp_tag(rsp_tag), .rsp_valid(rsp_valid),
    .wdog_err(wdog_err)
  );

  typedef struct {
    logic [63:0]      d1, d2, d3;
    logic [1:0]       fmt;
    logic [2:0]       rm;
    fp_operation_type op;
    logic [3:0]       tag;
  } ent_t;

  ent_t       mq[$];
  logic [3:0] tag_log[$];
  int         vectors = 0;
  int         miscompares = 0;
  logic [3:0] tag_ctr = '0;
  logic [3:0] cur_tag = '0;
  logic [3:0] exp_tag = '0;
  logic [63:0] exp_res = '0;
  logic [4:0] exp_flags = '0;
  bit         out_model = 0;
  bit         rsp_exp_v = 0;
  bit         wdog_exp = 0;
  int         stall = 0;
  int         wcnt = 0;

  task automatic chk(input string name, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic set_req(input bit en);
    logic [OPW-1:0] r;
    r = OPW'($urandom);
    req_enable = en;
    req_data1  = {$urandom, $urandom};
    req_data2  = {$urandom, $urandom};
    req_data3  = {$urandom, $urandom};
    req_fmt    = 2'($urandom);
    req_rm     = 3'($urandom);
    req_op     = r;
  endtask

  // One clock: check outputs at negedge, advance model, return at posedge+1.
  task automatic step();
    ent_t e;
    bit   full_exp, fire, issued;
    int   pend;
    @(negedge clock);
    pend     = mq.size();
    full_exp = (pend == DEPTH);
    chk("req_full", 64'(req_full), 64'(full_exp));
    chk("rsp_valid", 64'(rsp_valid), 64'(rsp_exp_v));
    if (rsp_exp_v) begin
      chk("rsp_result", rsp_result, exp_res);
      chk("rsp_flags", 64'(rsp_flags), 64'(exp_flags));
      chk("rsp_tag", 64'(rsp_tag), 64'(exp_tag));
      tag_log.push_back(rsp_tag);
    end
    chk("wdog_err", 64'(wdog_err), 64'(wdog_exp));
    issued = exe_enable;
    if (issued) begin
      chk("issue_legal", 64'(!out_model && pend != 0), 64'(1));
      if (pend != 0) begin
        e = mq.pop_front();
        chk("exe_data1", exe_data1, e.d1);
        chk("exe_data2", exe_data2, e.d2);
        chk("exe_data3", exe_data3, e.d3);
        chk("exe_fmt", 64'(exe_fmt), 64'(e.fmt));
        chk("exe_rm", 64'(exe_rm), 64'(e.rm));
        chk("exe_op", 64'(exe_op), 64'(e.op));
        cur_tag = e.tag;
      end
    end else begin
      chk("exe_op_idle", 64'(exe_op), 64'(init_fp_operation));
    end
    if (!out_model && !issued && pend != 0) stall++;
    else stall = 0;
    chk("issue_stall", 64'(stall > 1), 64'(0));
    fire      = exe_ready && out_model;
    rsp_exp_v = 0;
    if (fire) begin
      rsp_exp_v = 1;
      exp_res   = exe_result;
      exp_flags = exe_flags;
      exp_tag   = cur_tag;
      out_model = 0;
    end
`ifdef FP_QUEUE_WDOG_EN
    else if (out_model) begin
      wcnt++;
      if (wcnt == TIMEOUT) begin
        rsp_exp_v = 1;
        exp_res   = '0;
        exp_flags = '0;
        exp_tag   = cur_tag;
        out_model = 0;
        wdog_exp  = 1;
      end
    end
`endif
    if (issued) begin
      out_model = 1;
      wcnt      = 0;
    end
    if (req_enable && !full_exp) begin
      e = '{req_data1, req_data2, req_data3, req_fmt,
            req_rm, req_op, tag_ctr};
      mq.push_back(e);
      tag_ctr++;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b0;
    req_enable = 1'b0;
    exe_ready  = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_exe_enable", 64'(exe_enable), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_result", rsp_result, 64'(0));
    chk("rst_rsp_flags", 64'(rsp_flags), 64'(0));
    chk("rst_rsp_tag", 64'(rsp_tag), 64'(0));
    chk("rst_wdog_err", 64'(wdog_err), 64'(0));
    chk("rst_req_full", 64'(req_full), 64'(0));
    @(posedge clock);
    #1;
    reset = 1'b1;
    mq.delete();
    tag_log.delete();
    tag_ctr   = '0;
    out_model = 0;
    rsp_exp_v = 0;
    wdog_exp  = 0;
    stall     = 0;
    wcnt      = 0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    req_enable = 1'b0;
    while ((mq.size() != 0 || out_model || rsp_exp_v) && n < budget) begin
      exe_ready  = out_model;
      exe_result = {$urandom, $urandom};
      exe_flags  = 5'($urandom);
      step();
      n++;
    end
    chk("drain_done", 64'(n < budget), 64'(1));
    exe_ready = 1'b0;
  endtask

  initial begin
    int n;
    // single fadd op with 3-cycle unit latency
    do_reset();
    req_op       = init_fp_operation;
    req_op.fadd  = 1'b1;
    req_enable   = 1'b1;
    req_data1    = 64'h3F80_0000;
    req_data2    = 64'h4000_0000;
    req_data3    = '0;
    req_fmt      = 2'd0;
    req_rm       = 3'd0;
    step();
    req_enable = 1'b0;
    n = 0;
    while (!out_model && n < 6) begin
      step();
      n++;
    end
    chk("s1_issued", 64'(out_model), 64'(1));
    repeat (2) step();
    exe_ready  = 1'b1;
    exe_result = 64'h4040_0000;
    exe_flags  = 5'd0;
    step();
    exe_ready = 1'b0;
    step();
    chk("s1_rsp_count", 64'(tag_log.size()), 64'(1));
    if (tag_log.size() == 1)
      chk("s1_rsp_tag", 64'(tag_log[0]), 64'(0));

    // fill: five accepted, sixth dropped, drain in order
    do_reset();
    for (int i = 0; i < 6; i++) begin
      set_req(1'b1);
      step();
      if (i == 4) chk("fill_full", 64'(req_full), 64'(1));
    end
    drain(60);
    chk("fill_rsp_count", 64'(tag_log.size()), 64'(5));
    for (int i = 0; i < tag_log.size(); i++)
      chk("fill_tag", 64'(tag_log[i]), 64'(i));

    // tag wrap over 17 sequential ops
    do_reset();
    for (int i = 0; i < 17; i++) begin
      set_req(1'b1);
      step();
      drain(30);
    end
    chk("wrap_rsp_count", 64'(tag_log.size()), 64'(17));
    for (int i = 0; i < tag_log.size(); i++)
      chk("wrap_tag", 64'(tag_log[i]), 64'(i % 16));

    // push against pop around count DEPTH-1
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_req(1'b1);
      step();
    end
    for (int i = 0; i < 12; i++) begin
      set_req(1'b1);
      exe_ready = out_model;
      step();
    end
    drain(80);

    // reset while an op is outstanding, then a stray exe_ready
    do_reset();
    set_req(1'b1);
    step();
    req_enable = 1'b0;
    n = 0;
    while (!out_model && n < 6) begin
      step();
      n++;
    end
    step();
    do_reset();
    exe_ready = 1'b1;
    repeat (3) begin
      step();
      chk("rst_wait_valid", 64'(rsp_valid), 64'(0));
      chk("rst_wait_full", 64'(req_full), 64'(0));
      chk("rst_wait_en", 64'(exe_enable), 64'(0));
    end
    exe_ready = 1'b0;

`ifdef FP_QUEUE_WDOG_EN
    // watchdog expiry, then the next queued op still issues
    do_reset();
    for (int i = 0; i < 2; i++) begin
      set_req(1'b1);
      step();
    end
    req_enable = 1'b0;
    repeat (16) step();
    chk("wdog_set", 64'(wdog_err), 64'(1));
    chk("wdog_rsp_count", 64'(tag_log.size()), 64'(1));
    drain(40);
    chk("wdog_sticky", 64'(wdog_err), 64'(1));
`endif

    // random traffic, occasional reset
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      set_req($urandom_range(0, 99) < 45);
      exe_ready  = out_model ? ($urandom_range(0, 99) < 35)
                             : ($urandom_range(0, 99) < 10);
      exe_result = {$urandom, $urandom};
      exe_flags  = 5'($urandom);
      step();
      if ($urandom_range(0, 499) == 0) do_reset();
    end
    drain(80);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
